// File: rtl/vreg_file_pkg.sv
// Shared types and helpers for the multi-port vector register file.
// Optional build macro VREG_FILE_MP_BYPASS_EN (used by vreg_rd_port) enables
// same-cycle write-to-read forwarding.
package vreg_file_pkg;

    // Clear sequencer states: the array is zeroed in ST_CLEAR, user ports act in ST_IDLE.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Upper bounds for merge_lanes operands. An entry (lanes * bits per lane)
    // must fit in MERGE_MAX_BITS and the lane count in MERGE_MAX_LANES.
    localparam int unsigned MERGE_MAX_BITS  = 2048;
    localparam int unsigned MERGE_MAX_LANES = 64;

    // Per-lane merge: lanes with en=1 take new_v, the rest keep old_v.
    // Operands are zero-extended to the maximum width; callers truncate the result.
    function automatic logic [MERGE_MAX_BITS-1:0] merge_lanes(
        input logic [MERGE_MAX_BITS-1:0]  old_v,
        input logic [MERGE_MAX_BITS-1:0]  new_v,
        input logic [MERGE_MAX_LANES-1:0] en,
        input int unsigned                lanes,
        input int unsigned                lane_bits
    );
        logic [MERGE_MAX_BITS-1:0]  mask;
        logic [MERGE_MAX_BITS-1:0]  lane_mask;
        logic [MERGE_MAX_LANES-1:0] en_sh;
        mask      = '0;
        lane_mask = (MERGE_MAX_BITS'(1) << lane_bits) - MERGE_MAX_BITS'(1);
        for (int unsigned l = 0; l < MERGE_MAX_LANES; l++) begin
            en_sh = en >> l;
            if (l < lanes && en_sh[0]) begin
                mask = mask | (lane_mask << (l * lane_bits));
            end
        end
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/vreg_rd_port.sv
// One registered read port of vreg_file_mp: captures the addressed entry when
// enabled and raises rvalid for one cycle. With VREG_FILE_MP_BYPASS_EN defined,
// a same-cycle write to the same address is merged into the returned data.
module vreg_rd_port
    import vreg_file_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR   = 4,
    parameter int unsigned WIDTH_VECTOR = 8,
    parameter int unsigned N            = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
`ifdef VREG_FILE_MP_BYPASS_EN
    input  logic                                 wen,
    input  logic [WIDTH_ADDR-1:0]                waddr,
    input  logic [WIDTH_VECTOR-1:0]              wlane_en,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]       wdata,
    input  logic [WIDTH_ADDR-1:0]                addr,
`endif
    input  logic                                 en,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]       stored,
    output logic [WIDTH_VECTOR-1:0][N-1:0]       rdata,
    output logic                                 rvalid
);

    localparam int unsigned EW = WIDTH_VECTOR * N;

    logic [WIDTH_VECTOR-1:0][N-1:0] rd_next;

    // Select the value to capture: the stored entry, or the forwarded merge.
    always_comb begin
        rd_next = stored;
`ifdef VREG_FILE_MP_BYPASS_EN
        if (wen && (waddr == addr)) begin
            rd_next = EW'(merge_lanes(MERGE_MAX_BITS'(stored), MERGE_MAX_BITS'(wdata),
                                      MERGE_MAX_LANES'(wlane_en), WIDTH_VECTOR, N));
        end
`endif
    end

    // Registered read data (held when idle) and single-cycle valid pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= en;
            if (en) begin
                rdata <= rd_next;
            end
        end
    end

endmodule

// File: rtl/vreg_file_mp.sv
// Multi-port vector register file: 2^WIDTH_ADDR entries of WIDTH_VECTOR lanes
// x N bits, one lane-masked write port, NUM_RD registered read ports and a
// clear sequencer that zeroes the array after reset or on clr_req.
// Build macro VREG_FILE_MP_BYPASS_EN: same-cycle write data is forwarded to
// reads of the same address (default: reads return the pre-write entry).
module vreg_file_mp
    import vreg_file_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR   = 4,
    parameter int unsigned WIDTH_VECTOR = 8,
    parameter int unsigned N            = 32,
    parameter int unsigned NUM_RD       = 2
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         clr_req,
    output logic                                         busy,
    input  logic                                         we,
    input  logic [WIDTH_ADDR-1:0]                        waddr,
    input  logic [WIDTH_VECTOR-1:0]                      wlane_en,
    input  logic [WIDTH_VECTOR-1:0][N-1:0]               wdata,
    input  logic [NUM_RD-1:0]                            re,
    input  logic [NUM_RD-1:0][WIDTH_ADDR-1:0]            raddr,
    output logic [NUM_RD-1:0][WIDTH_VECTOR-1:0][N-1:0]   rdata,
    output logic [NUM_RD-1:0]                            rvalid
);

    localparam int unsigned DEPTH = 1 << WIDTH_ADDR;
    localparam int unsigned EW    = WIDTH_VECTOR * N;
    localparam logic [WIDTH_ADDR-1:0] LAST_ADDR = WIDTH_ADDR'(DEPTH - 1);

    state_e                 state;
    logic [WIDTH_ADDR-1:0]  clr_cnt;
    logic                   idle;
    logic                   user_we;
    logic [EW-1:0]          wr_merged;
    logic [EW-1:0]          mem [DEPTH];

    assign idle    = (state == ST_IDLE);
    assign user_we = we & idle;

    // Clear sequencer: one entry per cycle from address 0, then idle until clr_req.
    // clr_req is only looked at in ST_IDLE, so it cannot restart a running clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    // Lane-masked write value built from the current entry.
    always_comb begin
        wr_merged = EW'(merge_lanes(MERGE_MAX_BITS'(mem[waddr]), MERGE_MAX_BITS'(wdata),
                                    MERGE_MAX_LANES'(wlane_en), WIDTH_VECTOR, N));
    end

    // Array write: the clear sequencer owns the array while busy, else the user port.
    // No reset here on purpose; contents become defined once a clear completes.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (we && (wlane_en != '0)) begin
            mem[waddr] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic rd_en;
        assign rd_en = re[p] & idle;

        vreg_rd_port #(
            .WIDTH_ADDR   (WIDTH_ADDR),
            .WIDTH_VECTOR (WIDTH_VECTOR),
            .N            (N)
        ) u_rd_port (
            .clk      (clk),
            .rstn     (rstn),
`ifdef VREG_FILE_MP_BYPASS_EN
            .wen      (user_we),
            .waddr    (waddr),
            .wlane_en (wlane_en),
            .wdata    (wdata),
            .addr     (raddr[p]),
`endif
            .en       (rd_en),
            .stored   (mem[raddr[p]]),
            .rdata    (rdata[p]),
            .rvalid   (rvalid[p])
        );
    end

`ifndef VREG_FILE_MP_BYPASS_EN
    // Only consumed by the read ports when forwarding is built in.
    logic unused_user_we;
    assign unused_user_we = user_we;
`endif

endmodule

// File: tb/tb_vreg_file_mp.sv
// Self-checking bench for vreg_file_mp: directed scenarios plus randomized
// traffic against an array model; a monitor pops expected read results.
module tb_vreg_file_mp;

    localparam int WA    = 4;
    localparam int WV    = 8;
    localparam int NB    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 16;

    typedef logic [WV-1:0][NB-1:0] vec_t;
    typedef struct {
        int   due;
        vec_t data;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rstn = 1'b1;
    logic                         clr_req = 1'b0;
    logic                         busy;
    logic                         we = 1'b0;
    logic [WA-1:0]                waddr = '0;
    logic [WV-1:0]                wlane_en = '0;
    vec_t                         wdata = '0;
    logic [NR-1:0]                re = '0;
    logic [NR-1:0][WA-1:0]        raddr = '0;
    logic [NR-1:0][WV-1:0][NB-1:0] rdata;
    logic [NR-1:0]                rvalid;

    vreg_file_mp #(
        .WIDTH_ADDR   (WA),
        .WIDTH_VECTOR (WV),
        .N            (NB),
        .NUM_RD       (NR)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr_req  (clr_req),
        .busy     (busy),
        .we       (we),
        .waddr    (waddr),
        .wlane_en (wlane_en),
        .wdata    (wdata),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    vec_t model_mem [DEPTH];
    int   clear_left = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t last [NR];

    function automatic void check_vec(string name, int p, vec_t got, vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s port%0d cyc%0d: got %h expected %h", name, p, cyc, got, exp);
        end
    endfunction

    function automatic void check_bit(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc%0d: got %b expected %b", name, cyc, got, exp);
        end
    endfunction

    function automatic void check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic vec_t merge(vec_t old_v, vec_t new_v, logic [WV-1:0] en);
        vec_t r = old_v;
        for (int i = 0; i < WV; i++) if (en[i]) r[i] = new_v[i];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < WV; i++) v[i] = $urandom;
        return v;
    endfunction

    // Monitor: each falling edge, compare rvalid/rdata with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) begin
                exp_t e;
                bit   have;
                bit   exp_valid;
                have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (have) e = (p == 0) ? q0[0] : q1[0];
                exp_valid = have && (e.due == cyc);
                check_bit($sformatf("rvalid_p%0d", p), rvalid[p], exp_valid);
                if (exp_valid) begin
                    if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    check_vec("rdata", p, rdata[p], e.data);
                    last[p] = e.data;
                end else begin
                    if (have && e.due < cyc) begin
                        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    end
                    check_vec("rdata_hold", p, rdata[p], last[p]);
                end
            end
        end
    end

    // One clock of stimulus: predict reads, advance the model, check busy.
    task automatic step();
        if (clear_left == 0) begin
            for (int p = 0; p < NR; p++) begin
                if (re[p]) begin
                    exp_t e;
                    e.due  = cyc + 1;
                    e.data = model_mem[raddr[p]];
`ifdef VREG_FILE_MP_BYPASS_EN
                    if (we && waddr == raddr[p]) e.data = merge(e.data, wdata, wlane_en);
`endif
                    if (p == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
        @(posedge clk);
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (we) model_mem[waddr] = merge(model_mem[waddr], wdata, wlane_en);
            if (clr_req) begin
                clear_left = DEPTH;
                for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
            end
        end
        #1;
        check_bit("busy", busy, clear_left != 0);
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = '0; clr_req = 1'b0; wlane_en = '0;
    endtask

    task automatic wr(input int a, input logic [WV-1:0] en, input vec_t d);
        we = 1'b1; waddr = WA'(a); wlane_en = en; wdata = d;
        step();
        idle_inputs();
    endtask

    task automatic rd(input logic [NR-1:0] m, input int a0, input int a1);
        re = m; raddr[0] = WA'(a0); raddr[1] = WA'(a1);
        step();
        idle_inputs();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) rd(2'b11, a, DEPTH - 1 - a);
        step();
    endtask

    // Asynchronous reset: outputs must drop at once, before any clock edge.
    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        #1;
        check_bit("reset_busy", busy, 1'b1);
        for (int p = 0; p < NR; p++) begin
            check_bit($sformatf("reset_rvalid_p%0d", p), rvalid[p], 1'b0);
            check_vec("reset_rdata", p, rdata[p], '0);
            last[p] = '0;
        end
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    endtask

    initial begin
        for (int p = 0; p < NR; p++) last[p] = '0;
        #1;
        apply_reset();
        // Initial clear: busy for exactly DEPTH cycles, then all entries zero.
        for (int i = 0; i < DEPTH + 2; i++) step();
        read_all();

        // Partial-lane write over a preloaded entry.
        wr(3, 8'hFF, {8{32'h11111111}});
        wr(3, 8'h0F, {8{32'hA5A5A5A5}});
        wr(7, 8'hFF, rand_vec());
        wr(4, 8'h00, rand_vec());
        rd(2'b11, 3, 7);
        repeat (3) step();
        rd(2'b01, 4, 0);
        step();

        // Same-cycle write and read of address 5 (old value 0).
        we = 1'b1; waddr = 5; wlane_en = 8'hFF; wdata = {8{32'hDEADBEEF}};
        re = 2'b11; raddr[0] = 5; raddr[1] = 5;
        step();
        idle_inputs();
        rd(2'b10, 0, 5);
        step();

        // Randomized traffic with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            waddr = WA'($urandom);
            wlane_en = WV'($urandom);
            wdata = rand_vec();
            re = NR'($urandom);
            raddr[0] = WA'($urandom);
            raddr[1] = WA'($urandom);
            clr_req = ($urandom_range(0, 63) == 0);
            step();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Fill, then clr_req together with a write and reads; traffic during busy is ignored.
        for (int a = 0; a < DEPTH; a++) wr(a, 8'hFF, rand_vec());
        we = 1'b1; waddr = 9; wlane_en = 8'hFF; wdata = rand_vec();
        re = 2'b11; raddr[0] = 9; raddr[1] = 2; clr_req = 1'b1;
        step();
        for (int i = 0; i < DEPTH + 2; i++) begin
            we = 1'b1; waddr = WA'($urandom); wlane_en = 8'hFF; wdata = rand_vec();
            re = 2'b11; raddr[0] = WA'($urandom); raddr[1] = WA'($urandom);
            clr_req = 1'($urandom);
            if (i >= DEPTH - 1) begin
                we = 1'b0; re = '0; clr_req = 1'b0;
            end
            step();
        end
        idle_inputs();
        read_all();

        // Reset during a clear: clear restarts and lasts a full DEPTH cycles.
        wr(1, 8'hFF, rand_vec());
        clr_req = 1'b1;
        step();
        idle_inputs();
        repeat (5) step();
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) step();

        // Reset right after a read: the pending read data must not survive.
        wr(2, 8'hFF, rand_vec());
        rd(2'b11, 2, 2);
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) step();
        read_all();

        check_int("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
